mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised modulo-N up/down counter with synchronous load, clock enable and cascade terminal-count output. Generalises the 4-bit up counter to any width and any modulus. Instances chain through `tc` -> `clken` to build the clock's BCD digit chain (mod-10, mod-6, mod-24 stages) on the Spartan-3 board.

## Interface
- `WIDTH`, 4: counter width in bits.
- `MODULUS`, 16: count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in WIDTH: parallel load value.
- `loaden` in 1: load strobe, level-sensitive, sampled each edge.
- `clken` in 1: count enable.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `countout` out WIDTH: registered count value.
- `tc` out 1: combinational terminal count, cascade enable for the next stage.
- `wrap` out 1: registered one-cycle pulse, high in the cycle after a wrap edge.

## Operation
- Priority per edge: `reset` > `loaden` > `clken` > hold.
- `reset`: `countout` = 0, `wrap` = 0.
- `loaden`: `countout` <= `load` if `load` < MODULUS, else MODULUS-1 (clamped). Independent of `clken` and `up`. `wrap` = 0.
- `clken` & `up`: if `countout` == MODULUS-1, then `countout` <= 0 and `wrap` <= 1; else `countout` + 1.
- `clken` & !`up`: if `countout` == 0, then `countout` <= MODULUS-1 and `wrap` <= 1; else `countout` - 1.
- `clken` = 0 and no load: `countout` holds, `wrap` <= 0.
- `tc` = `clken` & ((`up` & `countout` == MODULUS-1) | (!`up` & `countout` == 0)).
  - `tc` is forced to 0 while `reset` or `loaden` is high.
- Arithmetic is done in WIDTH bits. When MODULUS == 2**WIDTH, natural overflow equals wrap; the explicit compare still applies.
- Direction changes take effect on the same edge they are sampled. No pipeline.

## Timing
- Latency: 1 cycle from `clken`/`loaden` sampled high to the new `countout`.
- `wrap` asserts on the same edge that `countout` takes the wrapped value, and lasts exactly one cycle per wrap.
- `tc` is combinational from `countout`, `clken`, `up`, `reset` and `loaden`. There is no register between cascaded stages: all stages update on the same edge.
- Reset mid-count: the next edge gives `countout` = 0 regardless of `loaden`/`clken`.
- Simultaneous `loaden` and a terminal `clken`: load wins, no wrap pulse, `tc` = 0.
- Reset values: `countout` = 0, `wrap` = 0, `tc` = 0.

## Configuration
- `MOD_UPDOWN_COUNTER_SATURATE_EN` defined: the counter saturates instead of wrapping.
  - Up at MODULUS-1 holds MODULUS-1.
  - Down at 0 holds 0.
  - `wrap` and `tc` are tied to 0.
  - Load clamping is unchanged.
- Macro undefined: modulo wrap behaviour as described above.

## Structure
- Package `counter_pkg` holds:
  - the direction encodings `DIR_UP` = 1 and `DIR_DOWN` = 0;
  - the clock digit moduli constants `MOD_SEC_LO` = 10, `MOD_SEC_HI` = 6 and `MOD_HOUR` = 24.
- One sub-module, `counter_tc_detect`, is natural. It is purely combinational and takes `countout`, `up` and MODULUS, producing `at_max` and `at_min`. The top module combines these into `tc`, `wrap` and the next-state logic.
- Elaboration check: MODULUS outside 2..2**WIDTH is a fatal error.

## Test plan
- WIDTH=4, MODULUS=10:
  - Reset, then `clken`=1, `up`=1 for 12 cycles -> `countout` goes 0..9, 0, 1.
  - `tc` is high in the cycle `countout`=9.
  - `wrap` is high for one cycle after the 9->0 edge.
- Down-count with `countout`=0, `clken`=1, `up`=0 -> `countout` becomes 9, `wrap` pulses, `tc` was high at 0.
- `loaden`=1 with `load`=4'b1010 (10) -> `countout`=9 (clamped). With `load`=5 -> `countout`=5, even when `clken`=0.
- `countout`=9, `up`=1, `clken`=1, `loaden`=1, `load`=3 -> `countout`=3, `wrap`=0, `tc`=0.
- Cascade mod-10 -> mod-6 with the stage0 `tc` driving the stage1 `clken`, 60 enables -> stage1 steps on every 10th enable and both stages return to 0 together. Also assert `reset` at count 37 -> both stages are 0 on the next edge.
- With `MOD_UPDOWN_COUNTER_SATURATE_EN`: 15 up-enables from 0 -> `countout` holds at 9, `wrap` and `tc` stay 0. Down from 0 -> holds at 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: direction encodings and clock digit moduli.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MOD_SEC_LO = 10;
    localparam int MOD_SEC_HI = 6;
    localparam int MOD_HOUR   = 24;

    // A modulus is usable only if it spans at least two states and fits in the counter width.
    function automatic bit modulus_ok(input int width, input int modulus);
        return (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/counter_tc_detect.sv
// Direction-qualified terminal detect: at_max when counting up at MODULUS-1, at_min when counting down at 0.
// Latency: purely combinational.
// Backpressure: none; no flow control.
module counter_tc_detect
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] countout,
    input  logic             up,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    assign at_max = (up == DIR_UP)   && (countout == MAX_VAL);
    assign at_min = (up == DIR_DOWN) && (countout == '0);

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clamped synchronous load, clock enable and cascade terminal count.
// Latency: 1 cycle from loaden/clken to countout; tc is combinational; wrap is a registered 1-cycle pulse.
// Backpressure: none; tc feeds the next stage's clken so all stages advance on the same edge.
// Build option: MOD_UPDOWN_COUNTER_SATURATE_EN makes the counter saturate at its limits, with wrap and tc tied low.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load,
    input  logic             loaden,
    input  logic             clken,
    input  logic             up,
    output logic [WIDTH-1:0] countout,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    // Reject a modulus that cannot be represented before anything is built.
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $fatal(1, "mod_updown_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic             at_max;
    logic             at_min;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    counter_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .countout (countout),
        .up       (up),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    assign at_term = at_max | at_min;

    // Extra top bit keeps the compare exact when MODULUS == 2**WIDTH.
    assign load_clamped = ({1'b0, load} < MOD_EXT) ? load : MAX_VAL;

`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
    assign tc = 1'b0;
`else
    // Cascade enable; suppressed while the stage is being reset or loaded so the next stage does not step.
    assign tc = clken & at_term & ~reset & ~loaden;
`endif

    // Count state: reset beats load beats enable beats hold; wrap pulses for exactly one cycle per wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            countout <= '0;
            wrap     <= 1'b0;
        end else if (loaden) begin
            countout <= load_clamped;
            wrap     <= 1'b0;
        end else if (clken) begin
            if (at_term) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
                countout <= countout;
                wrap     <= 1'b0;
`else
                countout <= (up == DIR_UP) ? '0 : MAX_VAL;
                wrap     <= 1'b1;
`endif
            end else begin
                countout <= (up == DIR_UP) ? countout + 1'b1 : countout - 1'b1;
                wrap     <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed vector table on a mod-10 stage plus a mod-10 -> mod-6 cascade.
// Latency: inputs driven on the falling edge, tc sampled before the rising edge, registers sampled 1 ns after it.
// Backpressure: none.
module tb_mod_updown_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Single mod-10 stage under vector test.
    logic       reset = 1'b0;
    logic [3:0] load = 4'd0;
    logic       loaden = 1'b0;
    logic       clken = 1'b0;
    logic       up = 1'b1;
    logic [3:0] countout;
    logic       tc;
    logic       wrap;

    mod_updown_counter #(.WIDTH(4), .MODULUS(MOD_SEC_LO)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .loaden   (loaden),
        .clken    (clken),
        .up       (up),
        .countout (countout),
        .tc       (tc),
        .wrap     (wrap)
    );

    // Cascade: mod-10 stage whose tc enables a mod-6 stage.
    logic       c_reset = 1'b0;
    logic       c_en = 1'b0;
    logic       c_up = 1'b1;
    logic       c_loaden = 1'b0;
    logic [3:0] c_load0 = 4'd0;
    logic [2:0] c_load1 = 3'd0;
    logic [3:0] s0_count;
    logic       s0_tc;
    logic       s0_wrap;
    logic [2:0] s1_count;
    logic       s1_tc;
    logic       s1_wrap;

    mod_updown_counter #(.WIDTH(4), .MODULUS(MOD_SEC_LO)) u_stage0 (
        .clk      (clk),
        .reset    (c_reset),
        .load     (c_load0),
        .loaden   (c_loaden),
        .clken    (c_en),
        .up       (c_up),
        .countout (s0_count),
        .tc       (s0_tc),
        .wrap     (s0_wrap)
    );

    mod_updown_counter #(.WIDTH(3), .MODULUS(MOD_SEC_HI)) u_stage1 (
        .clk      (clk),
        .reset    (c_reset),
        .load     (c_load1),
        .loaden   (c_loaden),
        .clken    (s0_tc),
        .up       (c_up),
        .countout (s1_count),
        .tc       (s1_tc),
        .wrap     (s1_wrap)
    );

    typedef struct {
        logic       reset;
        logic       loaden;
        logic [3:0] load;
        logic       clken;
        logic       up;
        logic       exp_tc;      // tc with these inputs applied, before the edge
        logic [3:0] exp_count;   // countout after the edge
        logic       exp_wrap;    // wrap after the edge
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic ld, input logic [3:0] lv,
                                input logic ce, input logic u, input logic etc,
                                input logic [3:0] ec, input logic ew);
        vec_t v;
        v.reset = r; v.loaden = ld; v.load = lv; v.clken = ce; v.up = u;
        v.exp_tc = etc; v.exp_count = ec; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

`ifndef MOD_UPDOWN_COUNTER_SATURATE_EN
    task automatic run_table();
        //            r  ld load ce up  tc cnt wr
        vecs.push_back(mk(1, 0, 4'd0, 1, 1, 0, 4'd0, 0));  // reset
        // up-count 0..9, 0, 1: tc only while sitting at 9, wrap after the 9->0 edge
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd1, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd2, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd3, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd4, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd5, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd6, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd7, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd8, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd9, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 1, 4'd0, 1));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd1, 0));
        // down through 0 -> 9 wrap
        vecs.push_back(mk(0, 0, 4'd0, 1, 0, 0, 4'd0, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 0, 1, 4'd9, 1));
        vecs.push_back(mk(0, 0, 4'd0, 1, 0, 0, 4'd8, 0));
        // hold
        vecs.push_back(mk(0, 0, 4'd0, 0, 1, 0, 4'd8, 0));
        // loads: clamp 10 and 15 to 9, load 5 with clken low
        vecs.push_back(mk(0, 1, 4'd10, 0, 1, 0, 4'd9, 0));
        vecs.push_back(mk(0, 1, 4'd15, 1, 1, 0, 4'd9, 0));
        vecs.push_back(mk(0, 1, 4'd5, 0, 0, 0, 4'd5, 0));
        vecs.push_back(mk(0, 1, 4'd9, 0, 1, 0, 4'd9, 0));
        // load beats a terminal up-count at 9
        vecs.push_back(mk(0, 1, 4'd3, 1, 1, 0, 4'd3, 0));
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd4, 0));
        // load beats a terminal down-count at 0
        vecs.push_back(mk(0, 1, 4'd0, 0, 1, 0, 4'd0, 0));
        vecs.push_back(mk(0, 1, 4'd7, 1, 0, 0, 4'd7, 0));
        vecs.push_back(mk(0, 0, 4'd0, 0, 0, 0, 4'd7, 0));
        // reset beats load and enable
        vecs.push_back(mk(1, 1, 4'd5, 1, 1, 0, 4'd0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset  = vecs[i].reset;
            loaden = vecs[i].loaden;
            load   = vecs[i].load;
            clken  = vecs[i].clken;
            up     = vecs[i].up;
            #1;
            if (i > 0) check($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), int'(countout), int'(vecs[i].exp_count));
            check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
        end
        @(negedge clk);
        reset = 1'b0; loaden = 1'b0; clken = 1'b0;
        #1;
        check("reset_tc", int'(tc), 0);
    endtask

    task automatic cascade_step(input int n, inout int m0, inout int m1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c_en = 1'b1;
            #1;
            check("casc_tc0", int'(s0_tc), int'(m0 == 9));
            @(posedge clk);
            #1;
            if (m0 == 9) begin
                m0 = 0;
                m1 = (m1 == 5) ? 0 : m1 + 1;
            end else begin
                m0 = m0 + 1;
            end
            check("casc_s0", int'(s0_count), m0);
            check("casc_s1", int'(s1_count), m1);
        end
    endtask

    task automatic run_cascade();
        int m0;
        int m1;
        @(negedge clk);
        c_reset = 1'b1;
        @(posedge clk);
        #1;
        check("casc_reset_s0", int'(s0_count), 0);
        check("casc_reset_s1", int'(s1_count), 0);
        @(negedge clk);
        c_reset = 1'b0;
        m0 = 0; m1 = 0;
        cascade_step(10, m0, m1);
        check("casc_s1_after10", int'(s1_count), 1);
        cascade_step(50, m0, m1);
        check("casc_60_s0", int'(s0_count), 0);
        check("casc_60_s1", int'(s1_count), 0);
        check("casc_60_s1_wrap", int'(s1_wrap), 1);
        cascade_step(37, m0, m1);
        check("casc_37_s0", int'(s0_count), 7);
        check("casc_37_s1", int'(s1_count), 3);
        @(negedge clk);
        c_reset = 1'b1;
        c_en    = 1'b1;
        @(posedge clk);
        #1;
        check("casc_midreset_s0", int'(s0_count), 0);
        check("casc_midreset_s1", int'(s1_count), 0);
        @(negedge clk);
        c_reset = 1'b0;
        c_en    = 1'b0;
    endtask
`else
    task automatic run_saturate();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("sat_reset", int'(countout), 0);
        @(negedge clk);
        reset = 1'b0; clken = 1'b1; up = 1'b1;
        for (int k = 0; k < 15; k++) begin
            #1;
            check("sat_up_tc", int'(tc), 0);
            @(posedge clk);
            #1;
            check("sat_up_count", int'(countout), (k < 9) ? k + 1 : 9);
            check("sat_up_wrap", int'(wrap), 0);
            @(negedge clk);
        end
        reset = 1'b1; clken = 1'b0;
        @(negedge clk);
        reset = 1'b0; clken = 1'b1; up = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("sat_dn_tc", int'(tc), 0);
            @(posedge clk);
            #1;
            check("sat_dn_count", int'(countout), 0);
            check("sat_dn_wrap", int'(wrap), 0);
            @(negedge clk);
        end
        clken = 1'b0;
    endtask
`endif

    initial begin
`ifndef MOD_UPDOWN_COUNTER_SATURATE_EN
        run_table();
        run_cascade();
`else
        run_saturate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
